// File: rtl/mdio_responder_if.sv
// rtl/mdio_responder_if.sv - MDIO pin bundle between station management and the responder
interface mdio_responder_if;
    logic mdc;
    logic mdio_i;
    logic mdio_o;
    logic mdio_oe;

    modport master (output mdc, output mdio_i, input mdio_o, input mdio_oe);
    modport slave  (input mdc, input mdio_i, output mdio_o, output mdio_oe);
endinterface

// File: rtl/mdio_responder.sv
// rtl/mdio_responder.sv - clause-22 MDIO responder with 8x16 register file (option: MDIO_NOPRE_EN)
module mdio_responder #(
    parameter logic [4:0]  PHYADDR = 5'b00111,
    parameter logic [15:0] ID1     = 16'h0141,
    parameter logic [15:0] ID2     = 16'h0DD1
) (
    input  logic            wb_clk,
    input  logic            wb_rst_n,
    mdio_responder_if.slave mdio,
    input  logic [15:0]     status_i,
    output logic [127:0]    regs_o,
    output logic            wr_stb,
    output logic [2:0]      wr_addr
);

`ifdef MDIO_NOPRE_EN
    localparam logic [5:0] PRE_RESUME = 6'd32;
`else
    localparam logic [5:0] PRE_RESUME = 6'd0;
`endif

    typedef enum logic [2:0] {S_PRE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [4:0]  phy_q, phy_d;
    logic [4:0]  reg_q, reg_d;
    logic        ign_q, ign_d;
    logic [15:0] sh_q, sh_d;
    logic        oe_q, oe_d;
    logic        o_q, o_d;
    logic        commit_q, commit_d;
    logic [15:0] regs_q [8];
    logic [15:0] regs_d [8];
    logic        wr_stb_q, wr_stb_d;
    logic [2:0]  wr_addr_q, wr_addr_d;
    logic [2:0]  mdc_sync_q;
    logic [1:0]  mdio_sync_q;
    logic        mdc_rise, bit_in, rd_act, wr_act;

    assign mdc_rise = mdc_sync_q[1] & ~mdc_sync_q[2];
    assign bit_in   = mdio_sync_q[1];
    // Registers 1..3 are read-only, so a write frame only commits for indices 0 and 4..7.
    assign rd_act   = (op_q == 2'b10) && !ign_q;
    assign wr_act   = (op_q == 2'b01) && !ign_q && (reg_q[4:3] == 2'b00)
                      && ((reg_q[2:0] == 3'd0) || (reg_q[2:0] >= 3'd4));

    assign mdio.mdio_o  = o_q;
    assign mdio.mdio_oe = oe_q;
    assign wr_stb       = wr_stb_q;
    assign wr_addr      = wr_addr_q;

    // Bring MDC/MDIO into the wb_clk domain; third MDC stage gives the rising-edge detect.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            mdc_sync_q  <= 3'b000;
            mdio_sync_q <= 2'b11;
        end else begin
            mdc_sync_q  <= {mdc_sync_q[1:0], mdio.mdc};
            mdio_sync_q <= {mdio_sync_q[0], mdio.mdio_i};
        end
    end

    // Frame state, shift register, pad drive and register file.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q   <= S_PRE;
            cnt_q     <= 6'd0;
            op_q      <= 2'b00;
            phy_q     <= 5'd0;
            reg_q     <= 5'd0;
            ign_q     <= 1'b0;
            sh_q      <= 16'h0000;
            oe_q      <= 1'b0;
            o_q       <= 1'b1;
            commit_q  <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= 3'd0;
            for (int i = 0; i < 8; i++) regs_q[i] <= 16'h0000;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            phy_q     <= phy_d;
            reg_q     <= reg_d;
            ign_q     <= ign_d;
            sh_q      <= sh_d;
            oe_q      <= oe_d;
            o_q       <= o_d;
            commit_q  <= commit_d;
            wr_stb_q  <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
            regs_q    <= regs_d;
        end
    end

    // Per-bit frame decode on each detected MDC rise; write commit lands one clock later.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        phy_d     = phy_q;
        reg_d     = reg_q;
        ign_d     = ign_q;
        sh_d      = sh_q;
        oe_d      = oe_q;
        o_d       = o_q;
        commit_d  = 1'b0;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        regs_d    = regs_q;

        if (commit_q) begin
            regs_d[reg_q[2:0]] = sh_q;
            wr_stb_d           = 1'b1;
            wr_addr_d          = reg_q[2:0];
        end

        if (mdc_rise) begin
            case (state_q)
                S_PRE: begin
                    if (bit_in) begin
                        if (cnt_q < 6'd32) cnt_d = cnt_q + 6'd1;
                    end else if (cnt_q >= 6'd32) begin
                        state_d = S_ST;
                        cnt_d   = 6'd0;
                    end else begin
                        cnt_d = 6'd0;
                    end
                end
                S_ST: begin
                    cnt_d = 6'd0;
                    if (bit_in) begin
                        state_d = S_OP;
                        op_d    = 2'b00;
                        ign_d   = 1'b0;
                    end else begin
                        state_d = S_PRE;
                    end
                end
                S_OP: begin
                    op_d = {op_q[0], bit_in};
                    if (cnt_q == 6'd1) begin
                        state_d = S_PHYAD;
                        cnt_d   = 6'd0;
                        if ((op_d != 2'b10) && (op_d != 2'b01)) ign_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
                S_PHYAD: begin
                    phy_d = {phy_q[3:0], bit_in};
                    if (cnt_q == 6'd4) begin
                        state_d = S_REGAD;
                        cnt_d   = 6'd0;
                        if (phy_d != PHYADDR) ign_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
                S_REGAD: begin
                    reg_d = {reg_q[3:0], bit_in};
                    if (cnt_q == 6'd4) begin
                        // Read value is frozen here so live status cannot tear mid-DATA.
                        state_d = S_TA;
                        cnt_d   = 6'd0;
                        if (reg_d[4:3] != 2'b00) begin
                            sh_d = 16'h0000;
                        end else begin
                            case (reg_d[2:0])
                                3'd1:    sh_d = status_i;
                                3'd2:    sh_d = ID1;
                                3'd3:    sh_d = ID2;
                                default: sh_d = regs_q[reg_d[2:0]];
                            endcase
                        end
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
                S_TA: begin
                    if (cnt_q == 6'd0) begin
                        cnt_d = 6'd1;
                        if (rd_act) begin
                            oe_d = 1'b1;
                            o_d  = 1'b0;
                        end
                    end else begin
                        state_d = S_DATA;
                        cnt_d   = 6'd0;
                        sh_d    = {sh_q[14:0], bit_in};
                        if (rd_act) o_d = sh_q[15];
                    end
                end
                S_DATA: begin
                    // Reads shift out and writes shift in through the same register.
                    sh_d = {sh_q[14:0], bit_in};
                    if (cnt_q == 6'd15) begin
                        state_d = S_PRE;
                        cnt_d   = PRE_RESUME;
                        if (rd_act) begin
                            oe_d = 1'b0;
                            o_d  = 1'b1;
                        end
                        if (wr_act) commit_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                        if (rd_act) o_d = sh_q[15];
                    end
                end
                default: begin
                    state_d = S_PRE;
                    cnt_d   = 6'd0;
                end
            endcase
        end
    end

    // Flatten the register file; read-only slots 1..3 are never written and read as zero.
    always_comb begin
        regs_o = '0;
        for (int i = 0; i < 8; i++) regs_o[16*i +: 16] = regs_q[i];
    end

endmodule

// File: tb/tb_mdio_responder.sv
// tb/tb_mdio_responder.sv - self-checking bench for mdio_responder
module tb_mdio_responder;
    logic         wb_clk = 1'b0;
    logic         wb_rst_n = 1'b0;
    logic [15:0]  status_i;
    logic [127:0] regs_o;
    logic         wr_stb;
    logic [2:0]   wr_addr;

    mdio_responder_if bus();

    mdio_responder dut (
        .wb_clk   (wb_clk),
        .wb_rst_n (wb_rst_n),
        .mdio     (bus.slave),
        .status_i (status_i),
        .regs_o   (regs_o),
        .wr_stb   (wr_stb),
        .wr_addr  (wr_addr)
    );

    always #5 wb_clk = ~wb_clk;

`ifdef MDIO_NOPRE_EN
    localparam bit NOPRE = 1'b1;
`else
    localparam bit NOPRE = 1'b0;
`endif

    int          tests = 0;
    int          fails = 0;
    int          stb_count = 0;
    logic [15:0] m_regs [8];
    logic [2:0]  m_wr_addr = 3'd0;
    logic        m_stb = 1'b0;
    bit          rd_window = 1'b0;
    bit          prev_complete = 1'b0;
    bit          chk_en = 1'b0;
    bit          tear = 1'b0;
    logic [15:0] rd;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] m_flat();
        logic [127:0] f;
        f = '0;
        for (int i = 0; i < 8; i++)
            if (i == 0 || i >= 4) f[16*i +: 16] = m_regs[i];
        return f;
    endfunction

    function automatic logic [15:0] m_read(input logic [4:0] rg, input logic [15:0] st);
        if (rg >= 5'd8) return 16'h0000;
        case (rg[2:0])
            3'd1:    return st;
            3'd2:    return 16'h0141;
            3'd3:    return 16'h0DD1;
            default: return m_regs[rg[2:0]];
        endcase
    endfunction

    // Compare process: register file, strobe, address and idle pad every cycle.
    always @(negedge wb_clk) begin
        if (chk_en) begin
            check("regs_o", regs_o, m_flat());
            check("wr_stb", {127'd0, wr_stb}, {127'd0, m_stb});
            check("wr_addr", {125'd0, wr_addr}, {125'd0, m_wr_addr});
            if (!rd_window) check("mdio_oe_idle", {127'd0, bus.mdio_oe}, 128'd0);
            if (wr_stb) stb_count++;
        end
    end

    // Station-management master: one full frame, MDC low/high 5 wb_clk each.
    task automatic frame(input int npre, input logic [1:0] op, input logic [4:0] phy,
                         input logic [4:0] rg, input logic [15:0] wd, input int rst_at,
                         output logic [15:0] rdata);
        logic        bits [$];
        int          t0, total, s0;
        bit          pre_ok, addressed, is_rd, commit, aborted;
        logic [15:0] exp_rd;
        pre_ok    = (npre >= 32) || (NOPRE && prev_complete);
        addressed = pre_ok && (phy == 5'd7) && (op == 2'b10 || op == 2'b01);
        is_rd     = addressed && (op == 2'b10);
        commit    = addressed && (op == 2'b01) && (rg < 5'd8) && !(rg >= 5'd1 && rg <= 5'd3)
                    && (rst_at < 0);
        aborted   = 1'b0;
        exp_rd    = m_read(rg, status_i);
        rdata     = 16'h0000;
        s0        = stb_count;
        for (int i = 0; i < npre; i++) bits.push_back(1'b1);
        bits.push_back(1'b0);
        bits.push_back(1'b1);
        bits.push_back(op[1]);
        bits.push_back(op[0]);
        for (int i = 4; i >= 0; i--) bits.push_back(phy[i]);
        for (int i = 4; i >= 0; i--) bits.push_back(rg[i]);
        bits.push_back(1'b1);
        bits.push_back(op == 2'b01 ? 1'b0 : 1'b1);
        for (int i = 15; i >= 0; i--) bits.push_back(op == 2'b01 ? wd[i] : 1'b1);
        t0    = npre + 14;
        total = bits.size();
        for (int b = 0; b < total; b++) begin
            bus.mdio_i = bits[b];
            if (b == rst_at) begin
                #1;
                wb_rst_n = 1'b0;
                for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
                m_wr_addr = 3'd0;
                aborted   = 1'b1;
                is_rd     = 1'b0;
            end
            if (tear && b == t0 + 6) status_i = 16'h0000;
            repeat (5) @(negedge wb_clk);
            if (b == rst_at) wb_rst_n = 1'b1;
            if (is_rd && b == t0 + 1)
                check("ta_drive", {126'd0, bus.mdio_oe, bus.mdio_o}, 128'd2);
            if (is_rd && b >= t0 + 2) begin
                check("rd_oe", {127'd0, bus.mdio_oe}, 128'd1);
                rdata[15 - (b - t0 - 2)] = bus.mdio_o;
            end
            if (is_rd && b == t0) rd_window = 1'b1;
            bus.mdc = 1'b1;
            repeat (4) @(posedge wb_clk);
            #1;
            if (b == total - 1 && commit) begin
                m_regs[rg[2:0]] = wd;
                m_wr_addr       = rg[2:0];
                m_stb           = 1'b1;
            end
            @(posedge wb_clk);
            #1 m_stb = 1'b0;
            @(negedge wb_clk);
            bus.mdc = 1'b0;
            if (b == total - 1) rd_window = 1'b0;
        end
        bus.mdio_i    = 1'b1;
        prev_complete = pre_ok && !aborted;
        check("stb_pulses", stb_count - s0, {127'd0, commit});
        if (is_rd) check("rd_data", rdata, exp_rd);
    endtask

    initial begin
        status_i   = 16'h1111;
        bus.mdc    = 1'b0;
        bus.mdio_i = 1'b1;
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
        repeat (3) @(negedge wb_clk);
        wb_rst_n = 1'b1;
        @(negedge wb_clk);
        check("rst_oe", {127'd0, bus.mdio_oe}, 128'd0);
        check("rst_o", {127'd0, bus.mdio_o}, 128'd1);
        check("rst_regs", regs_o, 128'd0);
        check("rst_wr_addr", {125'd0, wr_addr}, 128'd0);
        chk_en = 1'b1;

        frame(32, 2'b10, 5'd7, 5'd2, 16'h0000, -1, rd);
        check("read_id1", rd, 16'h0141);

        frame(32, 2'b01, 5'd7, 5'd5, 16'hA5C3, -1, rd);
        check("wr5_data", regs_o[95:80], 16'hA5C3);
        check("wr5_addr", {125'd0, wr_addr}, 128'd5);

        status_i = 16'h7949;
        tear     = 1'b1;
        frame(32, 2'b10, 5'd7, 5'd1, 16'h0000, -1, rd);
        tear     = 1'b0;
        check("read_status", rd, 16'h7949);
        status_i = 16'h1111;

        frame(32, 2'b01, 5'd3, 5'd4, 16'hDEAD, -1, rd);
        frame(32, 2'b10, 5'd3, 5'd5, 16'h0000, -1, rd);
        frame(32, 2'b01, 5'd7, 5'd2, 16'h5555, -1, rd);
        frame(32, 2'b11, 5'd7, 5'd4, 16'h3333, -1, rd);

        frame(31, 2'b01, 5'd7, 5'd6, 16'h2222, -1, rd);
        frame(32, 2'b01, 5'd7, 5'd6, 16'h1111, -1, rd);
        check("wr6_data", regs_o[111:96], 16'h1111);

        frame(32, 2'b01, 5'd7, 5'd4, 16'h1234, 32 + 24, rd);
        check("rst_mid_regs", regs_o, 128'd0);
        check("rst_mid_oe", {127'd0, bus.mdio_oe}, 128'd0);
        frame(32, 2'b01, 5'd7, 5'd7, 16'h0F0F, -1, rd);
        check("wr7_data", regs_o[127:112], 16'h0F0F);
        frame(32, 2'b10, 5'd7, 5'd7, 16'h0000, -1, rd);
        check("read_r7", rd, 16'h0F0F);
        frame(32, 2'b10, 5'd7, 5'd9, 16'h0000, -1, rd);
        check("read_unmapped", rd, 16'h0000);

        frame(32, 2'b01, 5'd7, 5'd0, 16'hCAFE, -1, rd);
        frame(0, 2'b01, 5'd7, 5'd6, 16'hBEEF, -1, rd);
        frame(0, 2'b10, 5'd7, 5'd3, 16'h0000, -1, rd);
        frame(32, 2'b10, 5'd7, 5'd0, 16'h0000, -1, rd);
        check("read_r0", rd, 16'hCAFE);

        repeat (10) @(negedge wb_clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end
endmodule
